// File: rtl/rvv_inst_decode_buf_if.sv
// rtl/rvv_inst_decode_buf_if.sv - issue and dispatch signal bundle for the RVV decode buffer
interface rvv_inst_decode_buf_if #(
  parameter int VLEN = 128,
  parameter int XLEN = 32
);
  localparam int VLW = $clog2(VLEN) + 1;

  logic            inst_valid_i;
  logic            inst_ready_o;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;

  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [6:0]      dec_inst_type_o;
  logic [2:0]      dec_alu_type_o;
  logic [7:0]      dec_alu_inst_o;
  logic [4:0]      dec_vd_o;
  logic [4:0]      dec_vs2_o;
  logic [4:0]      dec_vs1_o;
  logic            dec_vm_o;
  logic [1:0]      dec_lsu_mop_o;
  logic [4:0]      dec_lsu_umop_o;
  logic [2:0]      dec_lsu_nf_o;
  logic [2:0]      dec_lsu_width_o;
  logic [XLEN-1:0] dec_scalar_o;
  logic            dec_illegal_o;
  logic [31:0]     dec_vtype_o;
  logic [VLW-1:0]  dec_vl_o;

  modport slave (
    input  inst_valid_i, inst_i, rs1_data_i, rs2_data_i, dec_ready_i,
    output inst_ready_o, dec_valid_o, dec_inst_type_o, dec_alu_type_o, dec_alu_inst_o,
           dec_vd_o, dec_vs2_o, dec_vs1_o, dec_vm_o, dec_lsu_mop_o, dec_lsu_umop_o,
           dec_lsu_nf_o, dec_lsu_width_o, dec_scalar_o, dec_illegal_o, dec_vtype_o, dec_vl_o
  );

  modport master (
    output inst_valid_i, inst_i, rs1_data_i, rs2_data_i, dec_ready_i,
    input  inst_ready_o, dec_valid_o, dec_inst_type_o, dec_alu_type_o, dec_alu_inst_o,
           dec_vd_o, dec_vs2_o, dec_vs1_o, dec_vm_o, dec_lsu_mop_o, dec_lsu_umop_o,
           dec_lsu_nf_o, dec_lsu_width_o, dec_scalar_o, dec_illegal_o, dec_vtype_o, dec_vl_o
  );
endinterface

// File: rtl/rvv_inst_decode_buf.sv
// rtl/rvv_inst_decode_buf.sv - RVV instruction decoder owning vtype/vl, with a 2-entry output buffer
// Macro RVV_DEC_VSETVL_EN enables vsetvl; when undefined vsetvl decodes as illegal.
module rvv_inst_decode_buf #(
  parameter int VLEN = 128,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  rvv_inst_decode_buf_if.slave bus
);
  localparam int VLW = $clog2(VLEN) + 1;
  localparam logic [6:0]  OP_LD = 7'h07;
  localparam logic [6:0]  OP_ST = 7'h27;
  localparam logic [6:0]  OP_ALU = 7'h57;
  localparam logic [31:0] VILL_VTYPE = 32'h8000_0000;

  typedef struct packed {
    logic [31:0]     inst;
    logic [7:0]      alu_inst;
    logic [XLEN-1:0] scalar;
    logic            illegal;
    logic [31:0]     vtype;
    logic [VLW-1:0]  vl;
  } entry_t;

  entry_t          mem [2];
  entry_t          wr_entry;
  entry_t          head;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count_q;
  logic [1:0]      count_next;
  logic            ready_q;
  logic [31:0]     vtype_q;
  logic [VLW-1:0]  vl_q;

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_ld, is_st, is_alu, is_cfg;
  logic            is_vsetvli, is_vsetivli, is_vsetvl, is_vset;
  logic            illegal;
  logic [7:0]      alu_inst;
  logic [31:0]     req_vtype;
  logic [XLEN-1:0] avl;
  logic [XLEN-1:0] vlmax;
  logic [XLEN-1:0] vlmax_sew;
  logic [2:0]      vsew;
  logic [2:0]      vlmul;
  logic            vtype_ok;
  logic [31:0]     new_vtype;
  logic [VLW-1:0]  new_vl;
  logic            push;
  logic            pop;
  logic            unused_bits;

  assign inst   = bus.inst_i;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    is_ld       = (opcode == OP_LD);
    is_st       = (opcode == OP_ST);
    is_alu      = (opcode == OP_ALU);
    is_cfg      = is_alu && (funct3 == 3'b111);
    is_vsetvli  = is_cfg && !inst[31];
    is_vsetivli = is_cfg && (inst[31:30] == 2'b11);
`ifdef RVV_DEC_VSETVL_EN
    is_vsetvl   = is_cfg && (inst[31:25] == 7'b1000000);
`else
    is_vsetvl   = 1'b0;
`endif
    is_vset     = is_vsetvli || is_vsetivli || is_vsetvl;

    illegal = 1'b0;
    if (!(is_ld || is_st || is_alu))
      illegal = 1'b1;
    if (is_alu && (funct3 == 3'b001 || funct3 == 3'b101))
      illegal = 1'b1;
    if ((is_ld || is_st) && !(funct3 == 3'b000 || funct3 == 3'b101 ||
                              funct3 == 3'b110 || funct3 == 3'b111))
      illegal = 1'b1;
    if ((is_ld || is_st) && inst[28])
      illegal = 1'b1;
    // Reserved OPCFG encodings (and vsetvl when disabled) fall out here.
    if (is_cfg && !is_vset)
      illegal = 1'b1;
    if (!is_vset && vtype_q[31])
      illegal = 1'b1;

    alu_inst = 8'hFF;
    if (is_alu) begin
      case (funct3)
        3'b000, 3'b011, 3'b100: alu_inst = {2'b00, inst[31:26]};
        3'b010, 3'b110:         alu_inst = {2'b01, inst[31:26]};
        default:                alu_inst = 8'hFF;
      endcase
    end
  end

  always_comb begin
    req_vtype = '0;
    avl       = '0;
    if (is_vsetivli) begin
      req_vtype = {22'b0, inst[29:20]};
      avl       = XLEN'(inst[19:15]);
    end else begin
      req_vtype = is_vsetvl ? 32'(bus.rs2_data_i) : {21'b0, inst[30:20]};
      if (inst[19:15] != 5'd0)
        avl = bus.rs1_data_i;
      else if (inst[11:7] != 5'd0)
        avl = '1;
      else
        avl = XLEN'(vl_q);
    end

    vsew      = req_vtype[5:3];
    vlmul     = req_vtype[2:0];
    vtype_ok  = (req_vtype[30:8] == 23'd0) && (vsew <= 3'd2);
    vlmax_sew = XLEN'(VLEN / 8) >> vsew;
    vlmax     = '0;
    case (vlmul)
      3'b000:  vlmax = vlmax_sew;
      3'b001:  vlmax = vlmax_sew << 1;
      3'b010:  vlmax = vlmax_sew << 2;
      3'b011:  vlmax = vlmax_sew << 3;
      3'b110: begin
        vlmax    = vlmax_sew >> 2;
        vtype_ok = vtype_ok && (vsew == 3'd0);
      end
      3'b111: begin
        vlmax    = vlmax_sew >> 1;
        vtype_ok = vtype_ok && (vsew <= 3'd1);
      end
      default: vtype_ok = 1'b0;
    endcase

    new_vtype = vtype_ok ? req_vtype : VILL_VTYPE;
    new_vl    = vtype_ok ? VLW'((avl < vlmax) ? avl : vlmax) : '0;
  end

  always_comb begin
    wr_entry          = '0;
    wr_entry.inst     = inst;
    wr_entry.alu_inst = alu_inst;
    wr_entry.scalar   = bus.rs1_data_i;
    wr_entry.illegal  = illegal;
    wr_entry.vtype    = (is_vset && !illegal) ? new_vtype : vtype_q;
    wr_entry.vl       = (is_vset && !illegal) ? new_vl : vl_q;
  end

  assign push       = bus.inst_valid_i && ready_q;
  assign pop        = (count_q != 2'd0) && bus.dec_ready_i;
  assign count_next = count_q + {1'b0, push} - {1'b0, pop};

  // Ready is a flop so dec_ready_i never reaches inst_ready_o combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
      ready_q <= 1'b1;
      vtype_q <= VILL_VTYPE;
      vl_q    <= '0;
    end else if (flush_i) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count_q <= count_next;
      ready_q <= (count_next < 2'd2);
      if (push && is_vset && !illegal) begin
        vtype_q <= new_vtype;
        vl_q    <= new_vl;
      end
    end
  end

  assign head = mem[rd_ptr];

  assign bus.inst_ready_o    = ready_q;
  assign bus.dec_valid_o     = (count_q != 2'd0);
  assign bus.dec_inst_type_o = head.inst[6:0];
  assign bus.dec_alu_type_o  = head.inst[14:12];
  assign bus.dec_alu_inst_o  = head.alu_inst;
  assign bus.dec_vd_o        = head.inst[11:7];
  assign bus.dec_vs2_o       = head.inst[24:20];
  assign bus.dec_vs1_o       = head.inst[19:15];
  assign bus.dec_vm_o        = head.inst[25];
  assign bus.dec_lsu_mop_o   = head.inst[27:26];
  assign bus.dec_lsu_umop_o  = head.inst[24:20];
  assign bus.dec_lsu_nf_o    = head.inst[31:29];
  assign bus.dec_lsu_width_o = head.inst[14:12];
  assign bus.dec_scalar_o    = head.scalar;
  assign bus.dec_illegal_o   = head.illegal;
  assign bus.dec_vtype_o     = head.vtype;
  assign bus.dec_vl_o        = head.vl;

  assign unused_bits = ^{bus.rs2_data_i, head.inst[28]};
endmodule

// File: tb/tb_rvv_inst_decode_buf.sv
// tb/tb_rvv_inst_decode_buf.sv - randomized bench for rvv_inst_decode_buf against a queue-based model
// Honours RVV_DEC_VSETVL_EN the same way as the design.
module tb_rvv_inst_decode_buf;
  localparam int VLEN = 128;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [6:0]  itype;
    logic [2:0]  atype;
    logic [7:0]  ainst;
    logic [4:0]  vd;
    logic [4:0]  vs2;
    logic [4:0]  vs1;
    logic        vm;
    logic [1:0]  mop;
    logic [4:0]  umop;
    logic [2:0]  nf;
    logic [2:0]  width;
    logic [31:0] scalar;
    logic        ill;
    logic [31:0] vtype;
    logic [7:0]  vl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  exp_t        q[$];
  logic [31:0] m_vtype;
  int          m_vl;

  rvv_inst_decode_buf_if #(.VLEN(VLEN), .XLEN(XLEN)) bus ();

  rvv_inst_decode_buf #(.VLEN(VLEN), .XLEN(XLEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode: field extraction plus vtype/vl rules expressed as SEW and LMUL fractions.
  function automatic void model_decode(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2,
                                       input logic [31:0] cvt, input int cvl, output exp_t e,
                                       output bit upd, output logic [31:0] nvt, output int nvl);
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          ld, st, alu, vli, vivli, vlf, vset, ok;
    logic [31:0] rv;
    longint      avl;
    int          sew, num, den, vlmax;
    op = w[6:0];
    f3 = w[14:12];
    e.itype = op; e.atype = f3; e.vd = w[11:7]; e.vs2 = w[24:20]; e.vs1 = w[19:15];
    e.vm = w[25]; e.mop = w[27:26]; e.umop = w[24:20]; e.nf = w[31:29]; e.width = f3;
    e.scalar = r1;
    ld = (op == 7'h07); st = (op == 7'h27); alu = (op == 7'h57);
    if (alu && (f3 == 0 || f3 == 3 || f3 == 4)) e.ainst = {2'b00, w[31:26]};
    else if (alu && (f3 == 2 || f3 == 6))       e.ainst = {2'b01, w[31:26]};
    else                                         e.ainst = 8'hFF;
    vli   = alu && f3 == 7 && w[31] == 1'b0;
    vivli = alu && f3 == 7 && w[31:30] == 2'b11;
`ifdef RVV_DEC_VSETVL_EN
    vlf   = alu && f3 == 7 && w[31:25] == 7'h40;
`else
    vlf   = 1'b0;
`endif
    vset = vli || vivli || vlf;
    e.ill = 1'b0;
    if (!(ld || st || alu)) e.ill = 1'b1;
    if (alu && (f3 == 1 || f3 == 5)) e.ill = 1'b1;
    if ((ld || st) && !(f3 == 0 || f3 >= 5)) e.ill = 1'b1;
    if ((ld || st) && w[28]) e.ill = 1'b1;
    if (alu && f3 == 7 && !vset) e.ill = 1'b1;
    if (!vset && cvt[31]) e.ill = 1'b1;
    nvt = cvt; nvl = cvl; upd = 1'b0;
    if (vset && !e.ill) begin
      upd = 1'b1;
      if (vivli) begin
        rv  = {22'b0, w[29:20]};
        avl = longint'(w[19:15]);
      end else begin
        rv = vlf ? r2 : {21'b0, w[30:20]};
        if (w[19:15] != 0)     avl = longint'(r1);
        else if (w[11:7] != 0) avl = longint'(32'hFFFF_FFFF);
        else                   avl = longint'(cvl);
      end
      num = 1; den = 1;
      case (rv[2:0])
        3'd1: num = 2;
        3'd2: num = 4;
        3'd3: num = 8;
        3'd6: den = 4;
        3'd7: den = 2;
        default: ;
      endcase
      ok = (rv[30:8] == 0) && (rv[5:3] <= 2) && (rv[2:0] != 4) && (rv[2:0] != 5);
      sew = ok ? (8 << rv[5:3]) : 8;
      ok = ok && (sew * den <= 32);
      if (ok) begin
        vlmax = VLEN * num / (sew * den);
        nvt = rv;
        nvl = (avl < longint'(vlmax)) ? int'(avl) : vlmax;
      end else begin
        nvt = 32'h8000_0000;
        nvl = 0;
      end
    end
    e.vtype = nvt;
    e.vl = 8'(nvl);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_vtype = 32'h8000_0000;
        m_vl = 0;
      end else begin
        bit acc, pp, upd;
        exp_t e;
        logic [31:0] nvt;
        int nvl;
        acc = bus.inst_valid_i && (q.size() < 2);
        pp  = (q.size() != 0) && bus.dec_ready_i;
        if (flush) begin
          q.delete();
        end else begin
          if (pp) void'(q.pop_front());
          if (acc) begin
            model_decode(bus.inst_i, bus.rs1_data_i, bus.rs2_data_i, m_vtype, m_vl, e, upd, nvt, nvl);
            q.push_back(e);
            if (upd) begin
              m_vtype = nvt;
              m_vl = nvl;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", 64'(bus.inst_ready_o), 64'(q.size() < 2));
      check("valid", 64'(bus.dec_valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("inst_type", 64'(bus.dec_inst_type_o), 64'(q[0].itype));
        check("alu_type",  64'(bus.dec_alu_type_o),  64'(q[0].atype));
        check("alu_inst",  64'(bus.dec_alu_inst_o),  64'(q[0].ainst));
        check("vd",        64'(bus.dec_vd_o),        64'(q[0].vd));
        check("vs2",       64'(bus.dec_vs2_o),       64'(q[0].vs2));
        check("vs1",       64'(bus.dec_vs1_o),       64'(q[0].vs1));
        check("vm",        64'(bus.dec_vm_o),        64'(q[0].vm));
        check("mop",       64'(bus.dec_lsu_mop_o),   64'(q[0].mop));
        check("umop",      64'(bus.dec_lsu_umop_o),  64'(q[0].umop));
        check("nf",        64'(bus.dec_lsu_nf_o),    64'(q[0].nf));
        check("width",     64'(bus.dec_lsu_width_o), 64'(q[0].width));
        check("scalar",    64'(bus.dec_scalar_o),    64'(q[0].scalar));
        check("illegal",   64'(bus.dec_illegal_o),   64'(q[0].ill));
        check("vtype",     64'(bus.dec_vtype_o),     64'(q[0].vtype));
        check("vl",        64'(bus.dec_vl_o),        64'(q[0].vl));
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
    int n = 0;
    bus.inst_valid_i = 1'b1;
    bus.inst_i = w;
    bus.rs1_data_i = r1;
    bus.rs2_data_i = r2;
    while (!bus.inst_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(1), 64'(0));
    @(posedge clk);
    #1 bus.inst_valid_i = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 9);
    bus.rs2_data_i = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 7) == 0) bus.rs2_data_i = bus.rs2_data_i | (32'd1 << $urandom_range(8, 30));
    case (sel)
      0, 1: begin
        w[6:0] = 7'h57; w[14:12] = 3'b111; w[31] = 1'b0;
        w[30:20] = 11'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) w[28] = 1'b1;
        w[19:15] = 5'($urandom_range(0, 3));
        w[11:7] = 5'($urandom_range(0, 2));
      end
      2: begin
        w[6:0] = 7'h57; w[14:12] = 3'b111; w[31:30] = 2'b11;
        w[29:20] = 10'($urandom_range(0, 255));
      end
      3: begin
        w[6:0] = 7'h57; w[14:12] = 3'b111; w[31:25] = 7'h40;
        w[19:15] = 5'($urandom_range(0, 3));
        w[11:7] = 5'($urandom_range(0, 2));
      end
      4, 5: begin
        w[6:0] = 7'h57;
      end
      6, 7: begin
        w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h07 : 7'h27;
        if ($urandom_range(0, 3) != 0) w[28] = 1'b0;
      end
      9: begin
        w[6:0] = 7'h57; w[14:12] = 3'b000;
      end
      default: ;
    endcase
    bus.inst_i = w;
    bus.rs1_data_i = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
    bus.inst_valid_i = ($urandom_range(0, 2) != 0);
    bus.dec_ready_i = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 49) == 0);
  endtask

  localparam logic [31:0] VADD     = 32'h0221_80D7;
  localparam logic [31:0] VSETVLI  = 32'h0093_72D7;
  localparam logic [31:0] VSETI_RS = 32'hC053_F0D7;
  localparam logic [31:0] VSETI_E32 = 32'hC103_F0D7;
  localparam logic [31:0] VSETI_U3 = 32'hC101_F0D7;
  localparam logic [31:0] VLE32    = 32'h0200_E207;
  localparam logic [31:0] VLE_BAD  = 32'h0200_9207;
  localparam logic [31:0] VSETVL   = 32'h8031_70D7;

  initial begin
    bus.inst_valid_i = 1'b0;
    bus.inst_i = '0;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
    bus.dec_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.dec_valid_o), 64'(0));
    check("rst_ready", 64'(bus.inst_ready_o), 64'(1));
    check("rst_vtype", 64'(bus.dec_vtype_o), 64'(0));
    check("rst_vl", 64'(bus.dec_vl_o), 64'(0));
    check("rst_alu_inst", 64'(bus.dec_alu_inst_o), 64'(0));
    check("rst_scalar", 64'(bus.dec_scalar_o), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(VADD, 32'd0, 32'd0);
    @(negedge clk);
    check("vill_valid", 64'(bus.dec_valid_o), 64'(1));
    check("vill_illegal", 64'(bus.dec_illegal_o), 64'(1));

    send(VSETVLI, 32'd20, 32'd0);
    @(negedge clk);
    check("vsetvli_vtype", 64'(bus.dec_vtype_o), 64'h009);
    check("vsetvli_vl16", 64'(bus.dec_vl_o), 64'd16);
    check("vsetvli_illegal", 64'(bus.dec_illegal_o), 64'(0));
    send(VSETVLI, 32'd5, 32'd0);
    @(negedge clk);
    check("vsetvli_vl5", 64'(bus.dec_vl_o), 64'd5);

    send(VADD, 32'd0, 32'd0);
    @(negedge clk);
    check("vadd_alu_inst", 64'(bus.dec_alu_inst_o), 64'h00);
    check("vadd_alu_type", 64'(bus.dec_alu_type_o), 64'd0);
    check("vadd_vd", 64'(bus.dec_vd_o), 64'd1);
    check("vadd_vs2", 64'(bus.dec_vs2_o), 64'd2);
    check("vadd_vs1", 64'(bus.dec_vs1_o), 64'd3);
    check("vadd_vm", 64'(bus.dec_vm_o), 64'd1);
    check("vadd_illegal", 64'(bus.dec_illegal_o), 64'd0);

    send(VSETI_RS, 32'd0, 32'd0);
    @(negedge clk);
    check("rsvd_lmul_vtype", 64'(bus.dec_vtype_o), 64'h8000_0000);
    check("rsvd_lmul_vl", 64'(bus.dec_vl_o), 64'd0);
    check("rsvd_lmul_illegal", 64'(bus.dec_illegal_o), 64'd0);

    send(VSETI_E32, 32'd0, 32'd0);
    @(negedge clk);
    check("e32_vl", 64'(bus.dec_vl_o), 64'd4);

    send(VLE32, 32'h100, 32'd0);
    @(negedge clk);
    check("vle_type", 64'(bus.dec_inst_type_o), 64'h07);
    check("vle_width", 64'(bus.dec_lsu_width_o), 64'd6);
    check("vle_umop", 64'(bus.dec_lsu_umop_o), 64'd0);
    check("vle_nf", 64'(bus.dec_lsu_nf_o), 64'd0);
    check("vle_illegal", 64'(bus.dec_illegal_o), 64'd0);
    send(VLE_BAD, 32'h100, 32'd0);
    @(negedge clk);
    check("vle_bad_illegal", 64'(bus.dec_illegal_o), 64'd1);

    @(posedge clk);
    #1;
    bus.dec_ready_i = 1'b0;
    bus.inst_valid_i = 1'b1;
    bus.inst_i = 32'h0221_8057 | (32'd7 << 7);
    @(negedge clk);
    check("bp_ready0", 64'(bus.inst_ready_o), 64'd1);
    @(posedge clk);
    #1 bus.inst_i = 32'h0221_8057 | (32'd8 << 7);
    @(negedge clk);
    check("bp_ready1", 64'(bus.inst_ready_o), 64'd1);
    @(posedge clk);
    #1 bus.inst_i = 32'h0221_8057 | (32'd9 << 7);
    @(negedge clk);
    check("bp_full", 64'(bus.inst_ready_o), 64'd0);
    check("bp_head_a", 64'(bus.dec_vd_o), 64'd7);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_hold", 64'(bus.inst_ready_o), 64'd0);
    @(posedge clk);
    #1 bus.dec_ready_i = 1'b1;
    @(negedge clk);
    check("bp_full_pop", 64'(bus.inst_ready_o), 64'd0);
    check("bp_head_a2", 64'(bus.dec_vd_o), 64'd7);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_rise", 64'(bus.inst_ready_o), 64'd1);
    check("bp_head_b", 64'(bus.dec_vd_o), 64'd8);
    @(posedge clk);
    #1 bus.inst_valid_i = 1'b0;
    @(negedge clk);
    check("bp_head_c", 64'(bus.dec_vd_o), 64'd9);

    @(posedge clk);
    #1;
    bus.dec_ready_i = 1'b0;
    bus.inst_valid_i = 1'b1;
    bus.inst_i = VSETI_U3;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_valid_i = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_empty", 64'(bus.dec_valid_o), 64'd0);
    bus.dec_ready_i = 1'b1;
    send(VADD, 32'd0, 32'd0);
    @(negedge clk);
    check("flush_vl_kept", 64'(bus.dec_vl_o), 64'd4);
    check("flush_vtype_kept", 64'(bus.dec_vtype_o), 64'h10);

    send(VSETVL, 32'd100, 32'h0A);
    @(negedge clk);
`ifdef RVV_DEC_VSETVL_EN
    check("vsetvl_vtype", 64'(bus.dec_vtype_o), 64'h0A);
    check("vsetvl_vl", 64'(bus.dec_vl_o), 64'd32);
    check("vsetvl_illegal", 64'(bus.dec_illegal_o), 64'd0);
`else
    check("vsetvl_vtype", 64'(bus.dec_vtype_o), 64'h10);
    check("vsetvl_vl", 64'(bus.dec_vl_o), 64'd4);
    check("vsetvl_illegal", 64'(bus.dec_illegal_o), 64'd1);
`endif

    bus.dec_ready_i = 1'b0;
    send(VADD, 32'd9, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.dec_valid_o), 64'd0);
    check("async_rst_ready", 64'(bus.inst_ready_o), 64'd1);
    check("async_rst_vtype", 64'(bus.dec_vtype_o), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.dec_ready_i = 1'b1;
    send(VADD, 32'd0, 32'd0);
    @(negedge clk);
    check("post_rst_vill", 64'(bus.dec_illegal_o), 64'd1);

    repeat (3000) begin
      @(posedge clk);
      #1 rand_inputs();
    end
    @(posedge clk);
    #1;
    bus.inst_valid_i = 1'b0;
    bus.dec_ready_i = 1'b1;
    flush = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drained", 64'(bus.dec_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rvv_inst_decode_buf.md
# rvv_inst_decode_buf

Front-end instruction decoder for the RVV backend: accepts raw 32-bit vector instruction words over a valid/ready handshake and splits them into typed fields (`inst_type_e`, `alu_type_e`, `alu_inst_e` code, LSU mop/umop/nf/width, register indices). It owns the architectural vtype/vl state and executes vsetvli, vsetivli and vsetvl itself. Each decoded entry carries the vtype/vl snapshot that applies to it. A 2-entry output buffer decouples the issue side from the dispatch side.

## Interface
- `VLEN`, 128, vector register length in bits; VLMAX width `VLW = $clog2(VLEN)+1`
- `XLEN`, 32, scalar operand width
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush_i`  in  1  discard all buffered entries
- `inst_valid_i`  in  1  instruction word valid
- `inst_ready_o`  out  1  decoder can accept; equals !full and is registered
- `inst_i`  in  32  instruction word
- `rs1_data_i`  in  XLEN  scalar rs1 value, sampled with `inst_i`
- `rs2_data_i`  in  XLEN  scalar rs2 value, used by vsetvl only
- `dec_valid_o`  out  1  head entry valid
- `dec_ready_i`  in  1  consumer accepts head
- `dec_inst_type_o`  out  7  opcode: LD 0x07, ST 0x27, ALU 0x57
- `dec_alu_type_o`  out  3  funct3
- `dec_alu_inst_o`  out  8  {2'b00,funct6} for OPI*, {2'b01,funct6} for OPM*, 0xFF otherwise
- `dec_vd_o`, `dec_vs2_o`, `dec_vs1_o`  out  5 each  inst[11:7], inst[24:20], inst[19:15]
- `dec_vm_o`  out  1  inst[25]
- `dec_lsu_mop_o`  out  2  inst[27:26]
- `dec_lsu_umop_o`  out  5  inst[24:20]
- `dec_lsu_nf_o`  out  3  inst[31:29]
- `dec_lsu_width_o`  out  3  inst[14:12]
- `dec_scalar_o`  out  XLEN  rs1_data_i copy
- `dec_illegal_o`  out  1  instruction is illegal
- `dec_vtype_o`  out  32  vtype in effect (vill bit 31)
- `dec_vl_o`  out  VLW  vl in effect

## Operation
- Accept means `inst_valid_i & inst_ready_o`.
- On accept:
  - Decode the word combinationally and write it into the FIFO tail.
  - If the word is a vset*, update the `vtype_q`/`vl_q` state on the same edge. The entry carries the post-update values.
- Illegal conditions:
  - opcode is not LD, ST or ALU;
  - funct3 is OPFVV or OPFVF;
  - LD/ST width is not in {000,101,110,111};
  - LD/ST mew (inst[28]) is 1;
  - any non-vset instruction issued while `vtype_q.vill` = 1.
- Illegal entries are still enqueued, with `dec_illegal_o` = 1 and no state change.
- vset forms:
  - vsetvli: inst[31]=0, zimm = inst[30:20].
  - vsetivli: inst[31:30]=11, zimm = inst[29:20], AVL = uimm inst[19:15].
  - vsetvl: inst[31:25]=1000000, vtype = `rs2_data_i`.
- AVL for vsetvli/vsetvl:
  - rs1 ≠ 0: AVL = `rs1_data_i`.
  - rs1 = 0 and rd ≠ 0: AVL = all ones (selects VLMAX).
  - rs1 = 0 and rd = 0: vl = min(old vl, VLMAX).
- vtype legality:
  - vsew ∈ {000,001,010};
  - vlmul ∈ {110,111,000,001,010,011};
  - bits [30:8] are zero;
  - LMUL1/4 requires SEW8; LMUL1/2 requires SEW ≤ 16.
  - Illegal vtype sets vtype = 0x8000_0000 and vl = 0. The vset entry itself is not flagged illegal.
- VLMAX = (VLEN/8 >> vsew), then shifted left by vlmul for integer LMUL, or right by 2 (1/4) or 1 (1/2) for fractional LMUL.
- vl = min(AVL, VLMAX). The comparison is unsigned and done at XLEN width.

## Timing
- Latency: an instruction accepted at edge N appears at the outputs with `dec_valid_o` = 1 after edge N.
- Sustained throughput: 1 instruction/cycle.
- Buffer: 2-entry FIFO with registered count; `inst_ready_o` = (count < 2). There is no combinational path from `dec_ready_i` to `inst_ready_o`.
- Full with a pop in the same cycle: `inst_ready_o` is 0 that cycle. It rises after the edge.
- Empty FIFO: a push and a pop cannot coincide, because `dec_valid_o` is 0.
- Pointers are 1 bit and wrap modulo 2.
- `flush_i`:
  - count becomes 0 at the next edge.
  - An instruction accepted in the same cycle is discarded and does not update vtype/vl.
  - vtype/vl state is otherwise kept.
- Reset values:
  - `dec_valid_o` = 0, `inst_ready_o` = 1.
  - All `dec_*` data outputs = 0.
  - `vtype_q` = 0x8000_0000, `vl_q` = 0.
- Reset asserted mid-operation clears the buffer and state immediately (asynchronous).
- Outputs are driven from the head entry's registers. Contents are don't-care while `dec_valid_o` = 0.

## Configuration
- `RVV_DEC_VSETVL_EN`
  - Defined: vsetvl takes vtype from `rs2_data_i` as described above.
  - Undefined: vsetvl is decoded illegal (`dec_illegal_o` = 1) and vtype/vl are unchanged. `rs2_data_i` remains on the port but is ignored.

## Test plan
All scenarios use VLEN = 128.
- Legal vtype after reset: vsetvli x5,x6,e16,m2 (zimm 0x009), `rs1_data_i` = 20 → vtype 0x009, vl 16. Follow with `rs1_data_i` = 5 → vl 5.
- Illegal while vill set: after reset, vadd.vv v1,v2,v3 (0x022180D7) → `dec_illegal_o` = 1. After a legal vset, the same word gives alu_inst 0x00, alu_type 000, vd 1, vs2 2, vs1 3, vm 1, illegal 0.
- Reserved LMUL: vsetivli e8 with vlmul = 101, uimm 7 → vtype 0x8000_0000, vl 0, entry not flagged illegal.
- LSU decode: vle32.v v4,(x1) (width 110, mop 00) → inst_type 0x07, width 110, umop 0, nf 0. The same word with width 001 → illegal.
- Backpressure: hold `dec_ready_i` = 0 and present 3 instructions back-to-back → 2 accepted, `inst_ready_o` drops after the second. Release → outputs drain in order, and the third is accepted one cycle later.
- Flush collision: assert `flush_i` together with an accepted vsetivli (uimm 3) → FIFO empty next cycle, vl unchanged.
